rr_mux2_stream: RTL and testbench
=================================

Name: rr_mux2_stream

Overview:
- Sequential front-end for the 2:1 data mux path.
- Arbitrates two valid/ready input streams (d0, d1) with round-robin fairness and a configurable burst length.
- Drives the selected beat and its select into a single registered output stage, y/sel, toward downstream.
- Full throughput of 1 beat/cycle; 1-cycle latency from input accept to output valid.

Parameters:
WIDTH, 8, data width of d0, d1, y
BURST, 1, max consecutive beats granted to one source while the other is also valid; legal range is >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d0  input  WIDTH  source 0 data
d0_valid  input  1  source 0 beat available
d0_ready  output  1  source 0 beat accepted this cycle when high with d0_valid
d1  input  WIDTH  source 1 data
d1_valid  input  1  source 1 beat available
d1_ready  output  1  source 1 beat accepted this cycle when high with d1_valid
y  output  WIDTH  registered output data
sel  output  1  registered: source of the beat currently on y (0 = d0, 1 = d1)
y_valid  output  1  y/sel hold a valid beat
y_ready  input  1  downstream accepts y this cycle

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values (async):
  - y = 0, sel = 0, y_valid = 0.
  - last_sel = 1.
  - burst_cnt = BURST-1.
  - Any beat held in y is discarded; no partial state survives.
- Internal state:
  - last_sel, 1 bit: last granted source.
  - burst_cnt: width max(1, clog2(BURST)).
- load = !y_valid | y_ready (combinational). The output stage can take a new beat this cycle.
- Grant (combinational, g = granted source):
  - Only d0_valid: g = 0.
  - Only d1_valid: g = 1.
  - Both valid and burst_cnt < BURST-1: g = last_sel (stay).
  - Both valid and burst_cnt == BURST-1: g = ~last_sel (switch).
  - Neither valid: no grant.
- Ready outputs:
  - d0_ready = load & d0_valid & (g == 0).
  - d1_ready = load & d1_valid & (g == 1).
  - Never both high in the same cycle.
  - The losing source's ready is 0; it must hold its beat.
- Accept of source s (its valid & ready high) at a clock edge:
  - y <= d_s, sel <= s, y_valid <= 1.
  - If s == last_sel: burst_cnt <= min(burst_cnt+1, BURST-1).
  - If s != last_sel: last_sel <= s, burst_cnt <= 0.
- No accept and y_ready high: y_valid <= 0. y and sel keep their last value.
- Stall: while y_valid & !y_ready, y and sel are stable and both input readys are 0.
- Simultaneous drain and fill (y_valid & y_ready & accept): the new beat replaces the old in the same edge, with no bubble.
- BURST = 1: strict alternation under continuous contention.
- Uncontended streaming from one source is never throttled by BURST; the counter saturates.
- Data ordering per source is preserved. No beat is duplicated or dropped except by reset.

Test Plan:
- Reset then idle: rst_n low mid-run with y_valid = 1 -> y = 0, sel = 0, y_valid = 0, d0_ready = d1_ready = 0 immediately (async, before the next edge).
- Single source: d0 = 8'hA5, d0_valid = 1, d1_valid = 0, y_ready = 1 -> d0_ready = 1; next cycle y = A5, sel = 0, y_valid = 1. Repeat with d1 = 8'h3C -> sel = 1.
- Contention, BURST = 1: both valid continuously, y_ready = 1, d0 beats 10,11,12 and d1 beats 20,21,22 -> y sequence 10,20,11,21,12,22; sel 0,1,0,1,0,1; first grant is d0.
- Contention, BURST = 3: both valid, y_ready = 1 -> sel pattern 0,0,0,1,1,1,0,...
- Backpressure: y = 10 valid, y_ready = 0 for 4 cycles while both sources valid -> y/sel unchanged, both readys 0. Then y_ready = 1 -> next beat appears the following cycle with no gap.
- Drain to empty: single beat accepted, then valids low, y_ready = 1 -> y_valid falls 1 cycle after the beat is consumed, and y holds its last value.

Source files
------------

// File: rtl/rr_mux2_stream.sv
// Round-robin front-end for the 2:1 data mux: arbitrates two valid/ready streams
// with a per-source burst limit and registers the winning beat and its source.
module rr_mux2_stream #(
    parameter int WIDTH = 8,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic             d1_valid,
    output logic             d1_ready,
    output logic [WIDTH-1:0] y,
    output logic             sel,
    output logic             y_valid,
    input  logic             y_ready
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

    // Handshake: a beat moves on a source when its valid and ready are both high
    // at a rising edge; y moves downstream when y_valid and y_ready are both high.
    logic [WIDTH-1:0] y_q, y_d;
    logic             sel_q, sel_d;
    logic             y_valid_q, y_valid_d;
    logic             last_sel_q, last_sel_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic load;
    logic grant;
    logic accept;

    always_comb begin
        load = !y_valid_q | y_ready;

        if (d0_valid & d1_valid) begin
            grant = (burst_cnt_q == CNT_MAX) ? ~last_sel_q : last_sel_q;
        end else begin
            grant = d1_valid;
        end

        // Readys are held low while reset is asserted so no source sees an accept.
        d0_ready = rst_n & load & d0_valid & ~grant;
        d1_ready = rst_n & load & d1_valid & grant;
        accept   = d0_ready | d1_ready;

        y_d         = y_q;
        sel_d       = sel_q;
        y_valid_d   = y_valid_q;
        last_sel_d  = last_sel_q;
        burst_cnt_d = burst_cnt_q;

        if (accept) begin
            y_d       = grant ? d1 : d0;
            sel_d     = grant;
            y_valid_d = 1'b1;
            if (grant == last_sel_q) begin
                if (burst_cnt_q != CNT_MAX) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                last_sel_d  = grant;
                burst_cnt_d = '0;
            end
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    // Reset state makes the first contended grant go to d0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            sel_q       <= 1'b0;
            y_valid_q   <= 1'b0;
            last_sel_q  <= 1'b1;
            burst_cnt_q <= CNT_MAX;
        end else begin
            y_q         <= y_d;
            sel_q       <= sel_d;
            y_valid_q   <= y_valid_d;
            last_sel_q  <= last_sel_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign y       = y_q;
    assign sel     = sel_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Bench for rr_mux2_stream: two instances (BURST=1 and BURST=3) checked every cycle
// against a run-length arbitration model, plus directed spot checks.
module tb_rr_mux2_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];
    logic [7:0] y [2];
    logic       d0_valid [2];
    logic       d1_valid [2];
    logic       d0_ready [2];
    logic       d1_ready [2];
    logic       sel [2];
    logic       y_valid [2];
    logic       y_ready [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: output register contents, last granted source, run length.
    logic       m_yv [2];
    logic [7:0] m_y [2];
    logic       m_sel [2];
    logic       m_last [2];
    int         m_run [2];
    logic       acc0 [2];
    logic       acc1 [2];

    rr_mux2_stream #(.WIDTH(8), .BURST(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .d0(d0[0]), .d0_valid(d0_valid[0]), .d0_ready(d0_ready[0]),
        .d1(d1[0]), .d1_valid(d1_valid[0]), .d1_ready(d1_ready[0]),
        .y(y[0]), .sel(sel[0]), .y_valid(y_valid[0]), .y_ready(y_ready[0])
    );

    rr_mux2_stream #(.WIDTH(8), .BURST(3)) dut_b3 (
        .clk(clk), .rst_n(rst_n),
        .d0(d0[1]), .d0_valid(d0_valid[1]), .d0_ready(d0_ready[1]),
        .d1(d1[1]), .d1_valid(d1_valid[1]), .d1_ready(d1_ready[1]),
        .y(y[1]), .sel(sel[1]), .y_valid(y_valid[1]), .y_ready(y_ready[1])
    );

    function automatic int burst_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input int inst,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_yv[i]   = 1'b0;
            m_y[i]    = 8'h00;
            m_sel[i]  = 1'b0;
            m_last[i] = 1'b1;
            m_run[i]  = burst_of(i);
            acc0[i]   = 1'b0;
            acc1[i]   = 1'b0;
        end
    endtask

    // Called shortly after a falling edge with inputs already driven; checks the
    // registered outputs and readys, advances the model, and returns at the next
    // falling edge.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            logic g, ld, r0, r1;
            check("y_valid", i, 32'(y_valid[i]), 32'(m_yv[i]));
            check("y", i, 32'(y[i]), 32'(m_y[i]));
            check("sel", i, 32'(sel[i]), 32'(m_sel[i]));
            ld = !m_yv[i] || y_ready[i];
            if (d0_valid[i] && d1_valid[i])
                g = (m_run[i] >= burst_of(i)) ? !m_last[i] : m_last[i];
            else
                g = d1_valid[i];
            r0 = ld && d0_valid[i] && !g;
            r1 = ld && d1_valid[i] && g;
            check("d0_ready", i, 32'(d0_ready[i]), 32'(r0));
            check("d1_ready", i, 32'(d1_ready[i]), 32'(r1));
            acc0[i] = r0;
            acc1[i] = r1;
            if (r0 || r1) begin
                m_y[i]   = g ? d1[i] : d0[i];
                m_sel[i] = g;
                m_yv[i]  = 1'b1;
                if (g == m_last[i]) begin
                    m_run[i]++;
                end else begin
                    m_last[i] = g;
                    m_run[i]  = 1;
                end
            end else if (y_ready[i]) begin
                m_yv[i] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a falling edge; asserts reset between edges and checks the
    // asynchronous clear before releasing it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_y", i, 32'(y[i]), 32'h0);
            check("rst_sel", i, 32'(sel[i]), 32'h0);
            check("rst_y_valid", i, 32'(y_valid[i]), 32'h0);
            check("rst_d0_ready", i, 32'(d0_ready[i]), 32'h0);
            check("rst_d1_ready", i, 32'(d1_ready[i]), 32'h0);
            d0_valid[i] = 1'b0;
            d1_valid[i] = 1'b0;
            y_ready[i]  = 1'b1;
        end
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic       exp_sel_q [$];
        logic [7:0] seen_y0 [$];
        logic       seen_sel1 [$];
        int         c0 [2];
        int         c1 [2];
        int         lim;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d0[i] = 8'h00; d1[i] = 8'h00;
            d0_valid[i] = 1'b0; d1_valid[i] = 1'b0;
            y_ready[i] = 1'b1;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        // Single source, then the other source, then drain to empty.
        d0[0] = 8'hA5; d0_valid[0] = 1'b1;
        tick();
        check("single_d0_y", 0, 32'(y[0]), 32'hA5);
        check("single_d0_sel", 0, 32'(sel[0]), 32'h0);
        check("single_d0_valid", 0, 32'(y_valid[0]), 32'h1);
        d0_valid[0] = 1'b0;
        d1[0] = 8'h3C; d1_valid[0] = 1'b1;
        tick();
        check("single_d1_y", 0, 32'(y[0]), 32'h3C);
        check("single_d1_sel", 0, 32'(sel[0]), 32'h1);
        d1_valid[0] = 1'b0;
        tick();
        check("drain_valid", 0, 32'(y_valid[0]), 32'h0);
        check("drain_hold_y", 0, 32'(y[0]), 32'h3C);

        // Continuous contention on both instances.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            c0[i] = 0; c1[i] = 0;
            d0[i] = 8'h10; d1[i] = 8'h20;
            d0_valid[i] = 1'b1; d1_valid[i] = 1'b1;
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (y_valid[0]) seen_y0.push_back(y[0]);
            if (y_valid[1]) seen_sel1.push_back(sel[1]);
            for (int i = 0; i < 2; i++) begin
                lim = (i == 0) ? 3 : 6;
                if (acc0[i]) begin
                    c0[i]++;
                    d0[i] = 8'(16 + c0[i]);
                    d0_valid[i] = (c0[i] < lim);
                end
                if (acc1[i]) begin
                    c1[i]++;
                    d1[i] = 8'(32 + c1[i]);
                    d1_valid[i] = (c1[i] < lim);
                end
            end
        end
        exp_q = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        check("alt_count", 0, 32'(seen_y0.size()), 32'(exp_q.size()));
        for (int k = 0; k < seen_y0.size() && k < exp_q.size(); k++)
            check("alt_y_seq", 0, 32'(seen_y0[k]), 32'(exp_q[k]));
        exp_sel_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        check("burst3_count", 1, 32'(seen_sel1.size()), 32'(exp_sel_q.size()));
        for (int k = 0; k < seen_sel1.size() && k < exp_sel_q.size(); k++)
            check("burst3_sel_seq", 1, 32'(seen_sel1[k]), 32'(exp_sel_q[k]));

        // Backpressure with both sources waiting.
        do_reset();
        d0[0] = 8'h10; d1[0] = 8'h20;
        d0_valid[0] = 1'b1; d1_valid[0] = 1'b1;
        tick();
        check("bp_first_y", 0, 32'(y[0]), 32'h10);
        d0[0] = 8'h11;
        y_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            check("bp_hold_y", 0, 32'(y[0]), 32'h10);
            check("bp_hold_sel", 0, 32'(sel[0]), 32'h0);
            check("bp_d0_ready", 0, 32'(d0_ready[0]), 32'h0);
            check("bp_d1_ready", 0, 32'(d1_ready[0]), 32'h0);
            #1;
        end
        y_ready[0] = 1'b1;
        tick();
        check("bp_release_y", 0, 32'(y[0]), 32'h20);
        check("bp_release_sel", 0, 32'(sel[0]), 32'h1);
        check("bp_release_valid", 0, 32'(y_valid[0]), 32'h1);

        // Asynchronous reset while a beat is held and both sources are valid.
        d1[0] = 8'h21;
        do_reset();

        // Randomized traffic with sources holding beats until accepted.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc0[i] || !d0_valid[i]) begin
                    d0_valid[i] = ($urandom_range(0, 3) != 0);
                    d0[i] = 8'($urandom);
                end
                if (acc1[i] || !d1_valid[i]) begin
                    d1_valid[i] = ($urandom_range(0, 3) != 0);
                    d1[i] = 8'($urandom);
                end
                y_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
